// File: rtl/fmcw_sweep_seq_pkg.sv
// ---------------------------------------------------------------------------
// fmcw_sweep_seq_pkg
// Shared constants for the FMCW chirp sweep sequencer.
//   - reset defaults for the sweep limits and step
//   - configuration register addresses and the CTRL mode bit position
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package fmcw_sweep_seq_pkg;

  localparam int C_ADD_MIN_DEF = 13631;
  localparam int C_ADD_MAX_DEF = 14331;
  localparam int C_STEP_DEF    = 1;

  localparam logic [1:0] C_CFG_ADDR_MIN  = 2'd0;
  localparam logic [1:0] C_CFG_ADDR_MAX  = 2'd1;
  localparam logic [1:0] C_CFG_ADDR_STEP = 2'd2;
  localparam logic [1:0] C_CFG_ADDR_CTRL = 2'd3;

  // CTRL word: this bit selects sawtooth (1) or triangle (0); the low bits
  // below it carry the idle gap length in clock cycles.
  localparam int C_CTRL_MODE_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_GAP  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/fmcw_sweep_seq.sv
// ---------------------------------------------------------------------------
// fmcw_sweep_seq
// Chirp sweep sequencer. Owns the phase-increment accumulator and runs
// triangle or sawtooth chirps with a programmable idle gap. Limits written
// through the config port sit in shadow registers and are copied into the
// active set only when a chirp starts.
//
// Ports
//   CK_i        system clock
//   XARST_i     asynchronous active-low reset
//   CFG_WR_i    config write strobe (one cycle)
//   CFG_ADDR_i  0=ADD_MIN 1=ADD_MAX 2=STEP 3=CTRL
//   CFG_DAT_i   write data; CTRL: [15]=MODE, [C_GAP_W-2:0]=GAP
//   RUN_i       sweep enable level
//   ADDs_o      integer part of the accumulator (phase increment)
//   DN_XUP_o    high while ramping down
//   CHIRP_ST_o  one-cycle pulse on the first UP cycle of a chirp
//   GAP_o       high while in the idle gap
//   BUSY_o      high whenever the sequencer is not idle
//   CFG_ERR_o   sticky; a chirp start found ADD_MIN >= ADD_MAX
// ---------------------------------------------------------------------------
module fmcw_sweep_seq
  import fmcw_sweep_seq_pkg::*;
#(
  parameter int C_ADD_W  = 14,
  parameter int C_FRAC_W = 12,
  parameter int C_GAP_W  = 16
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic               CFG_WR_i,
  input  logic [1:0]         CFG_ADDR_i,
  input  logic [15:0]        CFG_DAT_i,
  input  logic               RUN_i,
  output logic [C_ADD_W-1:0] ADDs_o,
  output logic               DN_XUP_o,
  output logic               CHIRP_ST_o,
  output logic               GAP_o,
  output logic               BUSY_o,
  output logic               CFG_ERR_o
);

  localparam int ACC_W = C_ADD_W + C_FRAC_W;
  localparam logic [C_ADD_W-1:0]  ADD_MIN_RST = C_ADD_W'(C_ADD_MIN_DEF);
  localparam logic [C_ADD_W-1:0]  ADD_MAX_RST = C_ADD_W'(C_ADD_MAX_DEF);
  localparam logic [15:0]         STEP_RST    = 16'(C_STEP_DEF);
  localparam logic [C_FRAC_W-1:0] FRAC_ZERO   = '0;

  logic [C_ADD_W-1:0]  sh_min, sh_max, act_min, act_max, act_min_nxt, act_max_nxt;
  logic [15:0]         sh_step, act_step, act_step_nxt;
  logic                sh_mode, act_mode, act_mode_nxt;
  logic [C_GAP_W-2:0]  sh_gap, act_gap, act_gap_nxt;

  sweep_state_t        state, state_nxt;
  logic [ACC_W-1:0]    acc, acc_nxt;
  logic [C_GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic                err_nxt, chirp_nxt;
  logic                chirp_end, want_apply;

  logic [ACC_W-1:0]    min_acc, max_acc;
  logic [ACC_W:0]      up_sum, dn_lim;

  assign min_acc = {act_min, FRAC_ZERO};
  assign max_acc = {act_max, FRAC_ZERO};
  // One guard bit so the limit compares stay correct when MAX sits near
  // the top of the accumulator range and STEP is large.
  assign up_sum  = {1'b0, acc} + (ACC_W+1)'(act_step);
  assign dn_lim  = {1'b0, min_acc} + (ACC_W+1)'(act_step);

  assign ADDs_o  = acc[ACC_W-1:C_FRAC_W];

  // Shadow config registers: written any time, read only by a chirp start.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      sh_min  <= ADD_MIN_RST;
      sh_max  <= ADD_MAX_RST;
      sh_step <= STEP_RST;
      sh_mode <= 1'b0;
      sh_gap  <= '0;
    end else if (CFG_WR_i) begin
      case (CFG_ADDR_i)
        C_CFG_ADDR_MIN:  sh_min  <= CFG_DAT_i[C_ADD_W-1:0];
        C_CFG_ADDR_MAX:  sh_max  <= CFG_DAT_i[C_ADD_W-1:0];
        C_CFG_ADDR_STEP: sh_step <= CFG_DAT_i;
        default: begin
          sh_mode <= CFG_DAT_i[C_CTRL_MODE_BIT];
          sh_gap  <= CFG_DAT_i[C_GAP_W-2:0];
        end
      endcase
    end
  end

  // Next-state, accumulator and apply logic.
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    gap_cnt_nxt  = gap_cnt;
    act_min_nxt  = act_min;
    act_max_nxt  = act_max;
    act_step_nxt = act_step;
    act_mode_nxt = act_mode;
    act_gap_nxt  = act_gap;
    err_nxt      = CFG_ERR_o;
    chirp_nxt    = 1'b0;
    chirp_end    = 1'b0;
    want_apply   = 1'b0;

    case (state)
      ST_IDLE: begin
        acc_nxt = min_acc;
        if (RUN_i) want_apply = 1'b1;
      end
      ST_UP: begin
        // Sawtooth holds MAX for one visible cycle before the chirp ends;
        // triangle turns straight into DOWN showing MAX on its first cycle.
        if (act_mode && (acc == max_acc)) begin
          chirp_end = 1'b1;
        end else if (up_sum >= {1'b0, max_acc}) begin
          acc_nxt = max_acc;
          if (!act_mode) state_nxt = ST_DOWN;
        end else begin
          acc_nxt = up_sum[ACC_W-1:0];
        end
      end
      ST_DOWN: begin
        if ({1'b0, acc} <= dn_lim) chirp_end = 1'b1;
        else acc_nxt = acc - ACC_W'(act_step);
      end
      default: begin
        acc_nxt = min_acc;
        if (gap_cnt == '0) begin
          if (RUN_i) want_apply = 1'b1;
          else       state_nxt  = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - C_GAP_W'(1);
        end
      end
    endcase

    if (chirp_end) begin
      acc_nxt = min_acc;
      if (!RUN_i) begin
        state_nxt = ST_IDLE;
      end else if (act_gap != '0) begin
        state_nxt   = ST_GAP;
        gap_cnt_nxt = C_GAP_W'(act_gap) - C_GAP_W'(1);
      end else begin
        want_apply = 1'b1;
      end
    end

    // Chirp start: take the shadow set, or refuse it and park in IDLE at
    // the still-active minimum.
    if (want_apply) begin
      if (sh_min < sh_max) begin
        act_min_nxt  = sh_min;
        act_max_nxt  = sh_max;
        act_step_nxt = (sh_step == '0) ? 16'd1 : sh_step;
        act_mode_nxt = sh_mode;
        act_gap_nxt  = sh_gap;
        acc_nxt      = {sh_min, FRAC_ZERO};
        state_nxt    = ST_UP;
        chirp_nxt    = 1'b1;
      end else begin
        err_nxt   = 1'b1;
        acc_nxt   = min_acc;
        state_nxt = ST_IDLE;
      end
    end
  end

  // State, accumulator, active config and registered status flags.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state      <= ST_IDLE;
      acc        <= {ADD_MIN_RST, FRAC_ZERO};
      gap_cnt    <= '0;
      act_min    <= ADD_MIN_RST;
      act_max    <= ADD_MAX_RST;
      act_step   <= STEP_RST;
      act_mode   <= 1'b0;
      act_gap    <= '0;
      CFG_ERR_o  <= 1'b0;
      CHIRP_ST_o <= 1'b0;
      DN_XUP_o   <= 1'b0;
      GAP_o      <= 1'b0;
      BUSY_o     <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      gap_cnt    <= gap_cnt_nxt;
      act_min    <= act_min_nxt;
      act_max    <= act_max_nxt;
      act_step   <= act_step_nxt;
      act_mode   <= act_mode_nxt;
      act_gap    <= act_gap_nxt;
      CFG_ERR_o  <= err_nxt;
      CHIRP_ST_o <= chirp_nxt;
      DN_XUP_o   <= (state_nxt == ST_DOWN);
      GAP_o      <= (state_nxt == ST_GAP);
      BUSY_o     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fmcw_sweep_seq.sv
// ---------------------------------------------------------------------------
// tb_fmcw_sweep_seq
// Directed, table-driven bench for the chirp sweep sequencer. Expected
// outputs are worked out by hand from the sweep rules (accumulator in
// 1/4096 units, registered outputs).
// ---------------------------------------------------------------------------
module tb_fmcw_sweep_seq;
  import fmcw_sweep_seq_pkg::*;

  logic        ck;
  logic        xarst;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_dat;
  logic        run;
  logic [13:0] adds;
  logic        dn_xup, chirp_st, gap, busy, cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        run;
    logic [13:0] adds;
    logic        dn;
    logic        chirp;
    logic        gap;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs [34];

  fmcw_sweep_seq dut (
    .CK_i      (ck),
    .XARST_i   (xarst),
    .CFG_WR_i  (cfg_wr),
    .CFG_ADDR_i(cfg_addr),
    .CFG_DAT_i (cfg_dat),
    .RUN_i     (run),
    .ADDs_o    (adds),
    .DN_XUP_o  (dn_xup),
    .CHIRP_ST_o(chirp_st),
    .GAP_o     (gap),
    .BUSY_o    (busy),
    .CFG_ERR_o (cfg_err)
  );

  initial ck = 1'b0;
  always #10 ck = ~ck;

  function automatic vec_t mk(input logic r, input int a, input logic d,
                              input logic c, input logic g, input logic b,
                              input logic e);
    vec_t v;
    v.run = r; v.adds = 14'(a); v.dn = d; v.chirp = c;
    v.gap = g; v.busy = b; v.err = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic applyStimulus(input logic r);
    run = r;
    tick();
  endtask

  task automatic cfgWrite(input logic [1:0] a, input logic [15:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_dat = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int e_adds, input logic e_dn,
                             input logic e_chirp, input logic e_gap,
                             input logic e_busy, input logic e_err);
    logic [18:0] act, exp;
    act = {adds, dn_xup, chirp_st, gap, busy, cfg_err};
    exp = {14'(e_adds), e_dn, e_chirp, e_gap, e_busy, e_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got adds=%0d dn=%b cs=%b gap=%b busy=%b err=%b, want adds=%0d dn=%b cs=%b gap=%b busy=%b err=%b",
               name, adds, dn_xup, chirp_st, gap, busy, cfg_err,
               e_adds, e_dn, e_chirp, e_gap, e_busy, e_err);
    end
  endtask

  // Asserts reset between clock edges and checks the outputs before any
  // further edge arrives, then releases it with RUN_i low.
  task automatic doReset(input string name);
    #3;
    xarst = 1'b0;
    #1;
    checkOutput(name, 13631, 0, 0, 0, 0, 0);
    run = 1'b0;
    #2;
    xarst = 1'b1;
    tick();
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: busy still %b after %0d cycles, want 0", name, busy, budget);
    end
  endtask

  initial begin
    int exp_up [17];
    logic exp_dn [17];

    // Sawtooth MIN=100 MAX=102 STEP=0x800 GAP=5, RUN dropped after 2nd chirp start.
    vecs[0]  = mk(1, 100, 0, 1, 0, 1, 0);
    vecs[1]  = mk(1, 100, 0, 0, 0, 1, 0);
    vecs[2]  = mk(1, 101, 0, 0, 0, 1, 0);
    vecs[3]  = mk(1, 101, 0, 0, 0, 1, 0);
    vecs[4]  = mk(1, 102, 0, 0, 0, 1, 0);
    for (int i = 5; i < 10; i++) vecs[i] = mk(1, 100, 0, 0, 1, 1, 0);
    vecs[10] = mk(1, 100, 0, 1, 0, 1, 0);
    vecs[11] = mk(0, 100, 0, 0, 0, 1, 0);
    vecs[12] = mk(0, 101, 0, 0, 0, 1, 0);
    vecs[13] = mk(0, 101, 0, 0, 0, 1, 0);
    vecs[14] = mk(0, 102, 0, 0, 0, 1, 0);
    vecs[15] = mk(0, 100, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 100, 0, 0, 0, 0, 0);
    // Triangle, same limits, GAP=0: back-to-back chirps, then RUN dropped.
    vecs[17] = mk(1, 100, 0, 1, 0, 1, 0);
    vecs[18] = mk(1, 100, 0, 0, 0, 1, 0);
    vecs[19] = mk(1, 101, 0, 0, 0, 1, 0);
    vecs[20] = mk(1, 101, 0, 0, 0, 1, 0);
    vecs[21] = mk(1, 102, 1, 0, 0, 1, 0);
    vecs[22] = mk(1, 101, 1, 0, 0, 1, 0);
    vecs[23] = mk(1, 101, 1, 0, 0, 1, 0);
    vecs[24] = mk(1, 100, 1, 0, 0, 1, 0);
    vecs[25] = mk(1, 100, 0, 1, 0, 1, 0);
    vecs[26] = mk(0, 100, 0, 0, 0, 1, 0);
    vecs[27] = mk(0, 101, 0, 0, 0, 1, 0);
    vecs[28] = mk(0, 101, 0, 0, 0, 1, 0);
    vecs[29] = mk(0, 102, 1, 0, 0, 1, 0);
    vecs[30] = mk(0, 101, 1, 0, 0, 1, 0);
    vecs[31] = mk(0, 101, 1, 0, 0, 1, 0);
    vecs[32] = mk(0, 100, 1, 0, 0, 1, 0);
    vecs[33] = mk(0, 100, 0, 0, 0, 0, 0);

    cfg_wr = 1'b0; cfg_addr = '0; cfg_dat = '0; run = 1'b0;
    xarst = 1'b1;
    #2 xarst = 1'b0;
    #1 checkOutput("reset", 13631, 0, 0, 0, 0, 0);
    #4 xarst = 1'b1;
    tick();
    checkOutput("idle_after_reset", 13631, 0, 0, 0, 0, 0);

    // Default limits: first steps of the up ramp (one LSB per 4096 cycles).
    applyStimulus(1);
    checkOutput("dflt_start", 13631, 0, 1, 0, 1, 0);
    repeat (4095) tick();
    checkOutput("dflt_c4096", 13631, 0, 0, 0, 1, 0);
    tick();
    checkOutput("dflt_c4097", 13632, 0, 0, 0, 1, 0);
    doReset("reset_mid_up");

    cfgWrite(C_CFG_ADDR_MIN, 16'd100);
    cfgWrite(C_CFG_ADDR_MAX, 16'd102);
    cfgWrite(C_CFG_ADDR_STEP, 16'h0800);
    cfgWrite(C_CFG_ADDR_CTRL, 16'h8005);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].run);
      checkOutput($sformatf("saw[%0d]", i), int'(vecs[i].adds), vecs[i].dn,
                  vecs[i].chirp, vecs[i].gap, vecs[i].busy, vecs[i].err);
    end
    cfgWrite(C_CFG_ADDR_CTRL, 16'h0000);
    for (int i = 17; i < 34; i++) begin
      applyStimulus(vecs[i].run);
      checkOutput($sformatf("tri[%0d]", i - 17), int'(vecs[i].adds), vecs[i].dn,
                  vecs[i].chirp, vecs[i].gap, vecs[i].busy, vecs[i].err);
    end

    // Large step overshooting MAX, RUN dropped mid-UP: exact clamps at both ends.
    cfgWrite(C_CFG_ADDR_MAX, 16'd103);
    cfgWrite(C_CFG_ADDR_STEP, 16'h1FFF);
    applyStimulus(1); checkOutput("clamp_c1", 100, 0, 1, 0, 1, 0);
    applyStimulus(0); checkOutput("clamp_c2", 101, 0, 0, 0, 1, 0);
    applyStimulus(0); checkOutput("clamp_max", 103, 1, 0, 0, 1, 0);
    applyStimulus(0); checkOutput("clamp_dn", 101, 1, 0, 0, 1, 0);
    applyStimulus(0); checkOutput("clamp_min_idle", 100, 0, 0, 0, 0, 0);

    // Rejected config: MIN >= MAX.
    cfgWrite(C_CFG_ADDR_MIN, 16'd200);
    cfgWrite(C_CFG_ADDR_MAX, 16'd150);
    applyStimulus(1); checkOutput("reject_1", 100, 0, 0, 0, 0, 1);
    applyStimulus(1); checkOutput("reject_2", 100, 0, 0, 0, 0, 1);
    applyStimulus(0); checkOutput("reject_hold", 100, 0, 0, 0, 0, 1);
    cfgWrite(C_CFG_ADDR_MAX, 16'd300);
    applyStimulus(1); checkOutput("recover_start", 200, 0, 1, 0, 1, 1);
    run = 1'b0;
    waitIdle("recover_idle", 1000);
    checkOutput("recover_done", 200, 0, 0, 0, 0, 1);

    // MAX written on the very cycle a chirp starts: seen one chirp later.
    doReset("reset_clear_err");
    cfgWrite(C_CFG_ADDR_MIN, 16'd100);
    cfgWrite(C_CFG_ADDR_MAX, 16'd102);
    cfgWrite(C_CFG_ADDR_STEP, 16'h0800);
    run = 1'b1;
    cfg_wr = 1'b1; cfg_addr = C_CFG_ADDR_MAX; cfg_dat = 16'd104;
    tick();
    cfg_wr = 1'b0;
    checkOutput("maxupd_c1", 100, 0, 1, 0, 1, 0);
    exp_up = '{100, 101, 101, 102, 101, 101, 100, 100, 100, 101, 101, 102, 102, 103, 103, 104, 103};
    exp_dn = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("maxupd_c%0d", i + 2), exp_up[i], exp_dn[i],
                  (i == 7), 0, 1, 0);
    end
    doReset("reset_mid_down");
    checkOutput("idle_after_reset2", 13631, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmcw_sweep_seq.md
# fmcw_sweep_seq

Chirp sweep sequencer for the FMCW sonar front end. It owns the phase-increment accumulator that drives the wave counter and sin/cos tables, and runs sweeps as triangle or sawtooth chirps with a programmable idle gap. Sweep limits are configurable at run time; new values are shadowed and applied only at chirp boundaries. It also emits chirp-start and gap strobes so the TX delta-sigma and the mic I/Q IIRs can be muted or re-synchronised.

## Interface
- C_ADD_W, 14, integer width of the phase increment (ADDs_o)
- C_FRAC_W, 12, fractional bits of the sweep accumulator
- C_GAP_W, 16, width of the gap counter
- CK_i  in  1  system clock, 48 MHz
- XARST_i  in  1  reset; one clock, reset asynchronous and active-low
- CFG_WR_i  in  1  config write strobe, one cycle
- CFG_ADDR_i  in  2  0=ADD_MIN, 1=ADD_MAX, 2=STEP, 3=CTRL
- CFG_DAT_i  in  16  write data; CTRL: [15]=MODE (0 triangle, 1 sawtooth), [C_GAP_W-2:0]=GAP cycles
- RUN_i  in  1  level; sweep enable
- ADDs_o  out  C_ADD_W  phase increment = ACC[C_ADD_W+C_FRAC_W-1:C_FRAC_W]
- DN_XUP_o  out  1  1 while sweeping down
- CHIRP_ST_o  out  1  one-cycle pulse on the first UP cycle of each chirp
- GAP_o  out  1  high during GAP state
- BUSY_o  out  1  high whenever state != IDLE
- CFG_ERR_o  out  1  sticky; set when the shadow config is rejected at apply

## Operation
- Shadow regs reset to ADD_MIN=13631, ADD_MAX=14331, STEP=1, MODE=0, GAP=0. A write lands in the shadow reg on the cycle after the strobe.
- Active regs load from shadow at every chirp start: IDLE->UP, GAP->UP, and DOWN/UP->UP without a gap. Apply is rejected if ADD_MIN>=ADD_MAX. On reject: set CFG_ERR_o, go to IDLE, and drop ADDs_o to the active min. CFG_ERR_o clears only on reset.
- STEP=0 is treated as 1.
- ACC width is C_ADD_W+C_FRAC_W (26 bits), unsigned.
- FSM states: IDLE, UP, DOWN, GAP.
  - IDLE: ACC={active MIN,0}. If RUN_i=1, apply, then go to UP.
  - UP: if ACC+STEP>={MAX,0}, set ACC={MAX,0} and end the up ramp. Otherwise ACC+=STEP. End of ramp: triangle goes to DOWN. Sawtooth goes to chirp end, where ACC={MIN,0}.
  - DOWN: if ACC<=({MIN,0}+STEP), set ACC={MIN,0} and go to chirp end. Otherwise ACC-=STEP.
  - Chirp end: if RUN_i=0, go to IDLE. Else if GAP>0, go to GAP with the counter loaded to GAP-1. Else apply and go to UP.
  - GAP: ACC holds {MIN,0}. Count down; at 0, check RUN_i (0 -> IDLE), otherwise apply and go to UP.
- RUN_i deassert mid-chirp never truncates a ramp; the sequencer stops at the next chirp end.
- Arithmetic never wraps: the clamps guarantee MIN<=ACC>>C_FRAC_W<=MAX.

## Timing
- Every output is registered. Reset values: ADDs_o=13631, DN_XUP_o=0, CHIRP_ST_o=0, GAP_o=0, BUSY_o=0, CFG_ERR_o=0.
- RUN_i rising edge in IDLE: CHIRP_ST_o=1 and BUSY_o=1 on the next cycle, with ADDs_o=MIN.
- ACC changes every cycle in UP/DOWN. ADDs_o follows ACC with zero extra latency.
- Defaults, triangle: each ramp is 700·4096 cycles. Chirp period is 2·700·4096 cycles plus GAP.
- A config write in the same cycle as an apply is not seen by that apply; it takes effect at the next chirp start.
- Async reset mid-sweep returns everything to reset values immediately. State becomes IDLE.

## Structure
- Shared package holds:
  - reset defaults C_ADD_MIN_DEF=13631, C_ADD_MAX_DEF=14331, C_STEP_DEF=1
  - CFG address constants
  - state encoding (IDLE=0, UP=1, DOWN=2, GAP=3)
  - CTRL MODE bit index
- No sub-module. Single always block for the FSM and ACC, plus a config shadow block.

## Test plan
- Defaults, triangle, GAP=0, RUN_i=1 -> CHIRP_ST_o at cycle 1. ADDs_o steps 13631->14331 over 2,867,200 cycles, DN_XUP_o rises, ramp returns to 13631, then next CHIRP_ST_o.
- MIN=100, MAX=102, STEP=0x800, MODE=1, GAP=5 -> ADDs_o sequence 100,100,101,101,102, then GAP_o high for 5 cycles, then CHIRP_ST_o.
- STEP=0x1FFF crossing MAX -> ADDs_o clamps to exactly MAX, never exceeds it; DOWN clamps to exactly MIN.
- Write MIN=200, MAX=150, then RUN_i=1 -> CFG_ERR_o=1, BUSY_o stays 0. A valid rewrite followed by a RUN_i re-edge leaves CFG_ERR_o=1 but runs the sweep.
- MAX written mid-ramp -> current ramp uses the old MAX; the change shows after the next CHIRP_ST_o.
- RUN_i dropped mid-UP -> ramp completes through DOWN, then IDLE with BUSY_o=0. XARST_i pulse mid-DOWN -> ADDs_o=13631 and all flags 0 immediately.
